// File: rtl/csr_pkg.sv
// Shared CSR address map and Zicsr funct3 encodings for the machine-mode CSR file.
package csr_pkg;

   localparam logic [11:0] CSR_TOHOST       = 12'h51E;
   localparam logic [11:0] CSR_CYCLE        = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH       = 12'hC80;
   localparam logic [11:0] CSR_INSTRET      = 12'hC02;
   localparam logic [11:0] CSR_INSTRETH     = 12'hC82;
   localparam logic [11:0] CSR_SCRATCH_BASE = 12'h7C0;

   typedef enum logic [2:0] {
      CSR_RW  = 3'b001,
      CSR_RS  = 3'b010,
      CSR_RC  = 3'b011,
      CSR_RWI = 3'b101,
      CSR_RSI = 3'b110,
      CSR_RCI = 3'b111
   } csr_op_e;

endpackage

// File: rtl/csr_file_counter.sv
// Free-running W-bit up-counter with enable; wraps to zero after all-ones.
module csr_counter #(
   parameter int unsigned W = 64
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)   cnt_q <= '0;
      else if (inc) cnt_q <= cnt_q + 1'b1;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: Zicsr decode, scratch bank, cycle/instret counters and
// a tohost register handed to the host through a valid/ack handshake.
module csr_file
   import csr_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NSCRATCH = 4,
   parameter int unsigned CNT_W    = 64
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            csr_en,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic            retire,
   output logic [XLEN-1:0] rdata,
   output logic            illegal,
   output logic            stall,
   output logic            tohost_valid,
   output logic [XLEN-1:0] tohost_data,
   input  logic            tohost_ack
);

   logic [11:0]      addr;
   logic [4:0]       rs1_f;
   logic [2:0]       funct3;
   logic [XLEN-1:0]  op, old_val, new_val;
   logic             legal_op, wr_req, mapped, read_only;
   logic             acc_ok, we_tohost, we_scratch;
   logic [CNT_W-1:0] cycle_cnt, instret_cnt;
   logic [31:0]      cycle_hi, instret_hi;
   logic [XLEN-1:0]  scratch_q [NSCRATCH];
   logic [XLEN-1:0]  scratch_rd;
   logic             is_scratch;

   assign addr   = instr[31:20];
   assign rs1_f  = instr[19:15];
   assign funct3 = instr[14:12];
   assign op     = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_f} : rs1_data;

   csr_counter #(.W(CNT_W)) u_cycle (
      .clk(clk), .n_rst(n_rst), .inc(1'b1), .cnt(cycle_cnt)
   );

   csr_counter #(.W(CNT_W)) u_instret (
      .clk(clk), .n_rst(n_rst), .inc(retire), .cnt(instret_cnt)
   );

   if (CNT_W > 32) begin : g_hi
      assign cycle_hi   = cycle_cnt[63:32];
      assign instret_hi = instret_cnt[63:32];
   end else begin : g_no_hi
      assign cycle_hi   = '0;
      assign instret_hi = '0;
   end

   assign is_scratch = (addr[11:4] == CSR_SCRATCH_BASE[11:4]) &&
                       (32'(addr[3:0]) < NSCRATCH);

   always_comb begin
      scratch_rd = '0;
      for (int unsigned i = 0; i < NSCRATCH; i++)
         if (addr[3:0] == 4'(i)) scratch_rd = scratch_q[i];
   end

   // Address decode and old-value mux
   always_comb begin
      old_val   = '0;
      mapped    = 1'b1;
      read_only = 1'b0;
      if (is_scratch) begin
         old_val = scratch_rd;
      end else begin
         case (addr)
            CSR_TOHOST:   old_val = tohost_data;
            CSR_CYCLE:    begin old_val = XLEN'(cycle_cnt[31:0]);   read_only = 1'b1; end
            CSR_CYCLEH:   begin old_val = XLEN'(cycle_hi);          read_only = 1'b1; end
            CSR_INSTRET:  begin old_val = XLEN'(instret_cnt[31:0]); read_only = 1'b1; end
            CSR_INSTRETH: begin old_val = XLEN'(instret_hi);        read_only = 1'b1; end
            default:      mapped = 1'b0;
         endcase
      end
   end

   // Set/clear with a zero rs1/zimm field is a pure read
   always_comb begin
      new_val  = '0;
      legal_op = 1'b1;
      wr_req   = 1'b0;
      case (csr_op_e'(funct3))
         CSR_RW, CSR_RWI: begin new_val = op;            wr_req = 1'b1;           end
         CSR_RS, CSR_RSI: begin new_val = old_val | op;  wr_req = (rs1_f != 5'd0); end
         CSR_RC, CSR_RCI: begin new_val = old_val & ~op; wr_req = (rs1_f != 5'd0); end
         default:         legal_op = 1'b0;
      endcase
   end

   assign illegal    = csr_en && (!legal_op || !mapped || (read_only && wr_req));
   assign acc_ok     = csr_en && !illegal;
   assign stall      = acc_ok && wr_req && (addr == CSR_TOHOST) && tohost_valid && !tohost_ack;
   assign rdata      = acc_ok ? old_val : '0;
   assign we_tohost  = acc_ok && wr_req && (addr == CSR_TOHOST) && !stall;
   assign we_scratch = acc_ok && wr_req && is_scratch;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         tohost_valid <= 1'b0;
         tohost_data  <= '0;
      end else if (we_tohost) begin
         tohost_valid <= 1'b1;
         tohost_data  <= new_val;
      end else if (tohost_ack) begin
         tohost_valid <= 1'b0;
      end
   end

   for (genvar g = 0; g < NSCRATCH; g++) begin : g_scratch
      always_ff @(posedge clk or negedge n_rst) begin
         if (!n_rst)
            scratch_q[g] <= '0;
         else if (we_scratch && (addr[3:0] == 4'(g)))
            scratch_q[g] <= new_val;
      end
   end

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: stimulus queues expected CSR responses, a
// negedge monitor pops and compares them whenever a CSR access is presented.
module tb_csr_file;

   logic        clk = 1'b0;
   logic        n_rst, csr_en, retire, tohost_ack;
   logic [31:0] instr, rs1_data;
   logic [31:0] rdata, tohost_data;
   logic        illegal, stall, tohost_valid;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        ill;
      logic        stl;
      logic        chk_th;
      logic        tv;
      logic [31:0] td;
   } exp_t;

   exp_t sb[$];

   csr_file #(.XLEN(32), .NSCRATCH(4), .CNT_W(64)) dut (
      .clk(clk), .n_rst(n_rst), .csr_en(csr_en), .instr(instr),
      .rs1_data(rs1_data), .retire(retire), .rdata(rdata), .illegal(illegal),
      .stall(stall), .tohost_valid(tohost_valid), .tohost_data(tohost_data),
      .tohost_ack(tohost_ack)
   );

   always #5 clk = ~clk;

   function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (n_rst && csr_en) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_underflow: got unexpected access expected none");
         end else begin
            e = sb.pop_front();
            chk({e.name, ".rdata"},   rdata,          e.rdata);
            chk({e.name, ".illegal"}, 32'(illegal),   32'(e.ill));
            chk({e.name, ".stall"},   32'(stall),     32'(e.stl));
            if (e.chk_th) begin
               chk({e.name, ".tv"}, 32'(tohost_valid), 32'(e.tv));
               chk({e.name, ".td"}, tohost_data,       e.td);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // One CSR access cycle; entered and left at #1 after a rising edge
   task automatic csr(input string n, input logic [2:0] f3, input logic [11:0] a,
                      input logic [4:0] f, input logic [31:0] d, input logic ack,
                      input logic [31:0] er, input logic ei, input logic es,
                      input logic ct, input logic etv, input logic [31:0] etd);
      exp_t e;
      csr_en     = 1'b1;
      instr      = {a, f, f3, 5'd1, 7'h73};
      rs1_data   = d;
      tohost_ack = ack;
      retire     = 1'b0;
      e.name = n; e.rdata = er; e.ill = ei; e.stl = es;
      e.chk_th = ct; e.tv = etv; e.td = etd;
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic idle(input logic ret, input logic ack);
      csr_en     = 1'b0;
      instr      = '0;
      rs1_data   = '0;
      retire     = ret;
      tohost_ack = ack;
      @(posedge clk); #1;
   endtask

   initial begin
      n_rst = 1'b0; csr_en = 1'b0; instr = '0; rs1_data = '0;
      retire = 1'b0; tohost_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      csr("rd_cycle",  3'b010, 12'hC00, 5'd0, 0, 0, 32'd10, 0, 0, 0, 0, 0);
      csr("rd_cycleh", 3'b010, 12'hC80, 5'd0, 0, 0, 32'd0,  0, 0, 0, 0, 0);
      csr("rd_th_rst", 3'b010, 12'h51E, 5'd0, 0, 0, 32'd0,  0, 0, 1, 0, 0);

      csr("rw_scr1",   3'b001, 12'h7C1, 5'd1, 32'hDEADBEEF, 0, 32'd0, 0, 0, 0, 0, 0);
      csr("rci_scr1",  3'b111, 12'h7C1, 5'h0F, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      csr("rd_scr1",   3'b010, 12'h7C1, 5'd0, 0, 0, 32'hDEADBEE0, 0, 0, 0, 0, 0);
      csr("rd_scr0",   3'b010, 12'h7C0, 5'd0, 0, 0, 32'd0, 0, 0, 0, 0, 0);

      csr("th_wr1",    3'b001, 12'h51E, 5'd1, 32'd1, 0, 32'd0, 0, 0, 1, 0, 0);
      for (int unsigned i = 0; i < 3; i++)
         csr("th_stall", 3'b001, 12'h51E, 5'd1, 32'd2, 0, 32'd1, 0, 1, 1, 1, 32'd1);
      csr("th_ackwr",  3'b001, 12'h51E, 5'd1, 32'd2, 1, 32'd1, 0, 0, 1, 1, 32'd1);
      csr("th_rd2",    3'b010, 12'h51E, 5'd0, 0, 0, 32'd2, 0, 0, 1, 1, 32'd2);
      idle(0, 1);
      csr("th_acked",  3'b010, 12'h51E, 5'd0, 0, 0, 32'd2, 0, 0, 1, 0, 32'd2);
      idle(0, 1);
      csr("th_ack_idle", 3'b010, 12'h51E, 5'd0, 0, 0, 32'd2, 0, 0, 1, 0, 32'd2);

      csr("ill_wcycle", 3'b001, 12'hC00, 5'd1, 32'h55, 0, 32'd0, 1, 0, 0, 0, 0);
      csr("ill_f100",   3'b100, 12'h7C0, 5'd1, 32'h55, 0, 32'd0, 1, 0, 0, 0, 0);
      csr("ill_f000",   3'b000, 12'h7C1, 5'd1, 32'h55, 0, 32'd0, 1, 0, 0, 0, 0);
      csr("ill_unmap",  3'b010, 12'h7C4, 5'd0, 0, 0, 32'd0, 1, 0, 0, 0, 0);
      csr("ill_rs_ro",  3'b010, 12'hC02, 5'd3, 32'h1, 0, 32'd0, 1, 0, 0, 0, 0);
      csr("scr0_same",  3'b010, 12'h7C0, 5'd0, 0, 0, 32'd0, 0, 0, 0, 0, 0);
      csr("scr1_same",  3'b010, 12'h7C1, 5'd0, 0, 0, 32'hDEADBEE0, 0, 0, 0, 0, 0);
      csr("rd_instret0", 3'b010, 12'hC02, 5'd0, 0, 0, 32'd0, 0, 0, 0, 0, 0);

      repeat (5) idle(1, 0);
      csr("rd_instret5", 3'b010, 12'hC02, 5'd0, 0, 0, 32'd5, 0, 0, 0, 0, 0);

      force dut.u_instret.cnt_q = 64'h0000_0000_FFFF_FFFF;
      #1 release dut.u_instret.cnt_q;
      idle(1, 0);
      csr("rd_instreth", 3'b010, 12'hC82, 5'd0, 0, 0, 32'd1, 0, 0, 0, 0, 0);
      csr("rd_instretl", 3'b010, 12'hC02, 5'd0, 0, 0, 32'd0, 0, 0, 0, 0, 0);

      csr("th_wr7",    3'b101, 12'h51E, 5'd7, 0, 0, 32'd2, 0, 0, 1, 0, 32'd2);
      csr("th_rd7",    3'b010, 12'h51E, 5'd0, 0, 0, 32'd7, 0, 0, 1, 1, 32'd7);
      csr_en = 1'b0;
      #2 n_rst = 1'b0;
      #1;
      chk("rst_async.tv", 32'(tohost_valid), 32'd0);
      chk("rst_async.td", tohost_data, 32'd0);
      @(posedge clk); #1;
      n_rst = 1'b1;
      csr("th_after_rst", 3'b001, 12'h51E, 5'd1, 32'd3, 0, 32'd0, 0, 0, 1, 0, 0);
      csr("th_rd3",       3'b010, 12'h51E, 5'd0, 0, 0, 32'd3, 0, 0, 1, 1, 32'd3);
      idle(0, 0);
      idle(0, 0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
